// File: rtl/bounce_chk_pkg.sv
// Shared types and helpers for the bounce counter stream checker.
package bounce_chk_pkg;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    HUNT0 = 3'd1,
    UP    = 3'd2,
    TOP   = 3'd3,
    DOWN  = 3'd4,
    BOT   = 3'd5
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // TOP already has the first MAX and expects the repeat, so it counts as descending.
  function automatic logic state_dir(input state_t s);
    case (s)
      TOP, DOWN: state_dir = DIR_DOWN;
      default:   state_dir = DIR_UP;
    endcase
  endfunction

  function automatic logic state_locked(input state_t s);
    case (s)
      UP, TOP, DOWN, BOT: state_locked = 1'b1;
      default:            state_locked = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bounce_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment in the clear cycle leaves it at 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_ZERO = {W{1'b0}};
  localparam logic [W-1:0] Q_ONE  = W'(1);
  localparam logic [W-1:0] Q_MAX  = {W{1'b1}};

  // Count register: reset, clear (increment wins over clear), saturating increment.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      q <= Q_ZERO;
    end else if (clr) begin
      q <= inc ? Q_ONE : Q_ZERO;
    end else if (inc && (q != Q_MAX)) begin
      q <= q + Q_ONE;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/bounce_seq_checker.sv
// Receive-side checker for the bounce counter stream 0..MAX,MAX..0,0,...
// Optional capture of the last mismatch (ErrExp/ErrGot/ClrCapture) under macro BOUNCE_CHK_CAPTURE_EN.
module bounce_seq_checker
  import bounce_chk_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int PER_CNT_W = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [WIDTH-1:0]     In,
  input  logic                 Valid,
`ifdef BOUNCE_CHK_CAPTURE_EN
  input  logic                 ClrCapture,
  output logic [WIDTH-1:0]     ErrExp,
  output logic [WIDTH-1:0]     ErrGot,
`endif
  output logic                 Locked,
  output logic                 Dir,
  output logic                 Error,
  output logic                 PeriodTick,
  output logic [ERR_CNT_W-1:0] ErrCnt,
  output logic [PER_CNT_W-1:0] PeriodCnt
);

  localparam logic [WIDTH-1:0]     ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0]     TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0]     MAX     = {WIDTH{1'b1}};
  localparam logic [PER_CNT_W-1:0] PER_ZERO = {PER_CNT_W{1'b0}};
  localparam logic [PER_CNT_W-1:0] PER_ONE  = PER_CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] next_exp_s;
  logic             mismatch_s;
  logic             period_done_s;
  logic             clr_s;

  // Next-state and expected-value logic; endpoint branches are tested before Exp moves.
  always_comb begin
    next_state_s  = state_r;
    next_exp_s    = exp_r;
    mismatch_s    = 1'b0;
    period_done_s = 1'b0;
    if (Valid) begin
      case (state_r)
        HUNT: begin
          if (In == ZERO) next_state_s = HUNT0;
          else            next_state_s = HUNT;
        end
        HUNT0: begin
          if (In == ONE) begin
            next_state_s = UP;
            next_exp_s   = TWO;
          end else if (In == ZERO) begin
            next_state_s = HUNT0;
          end else begin
            next_state_s = HUNT;
          end
        end
        UP: begin
          if (In != exp_r)       mismatch_s   = 1'b1;
          else if (exp_r == MAX) next_state_s = TOP;
          else                   next_exp_s   = exp_r + ONE;
        end
        TOP: begin
          if (In == MAX) begin
            next_state_s = DOWN;
            next_exp_s   = MAX - ONE;
          end else begin
            mismatch_s = 1'b1;
          end
        end
        DOWN: begin
          if (In != exp_r)        mismatch_s   = 1'b1;
          else if (exp_r == ZERO) next_state_s = BOT;
          else                    next_exp_s   = exp_r - ONE;
        end
        BOT: begin
          if (In == ZERO) begin
            next_state_s  = UP;
            next_exp_s    = ONE;
            period_done_s = 1'b1;
          end else begin
            mismatch_s = 1'b1;
          end
        end
        default: next_state_s = HUNT;
      endcase
      // A failing sample that is itself 0 may already be the start of the bottom hold.
      if (mismatch_s) begin
        next_state_s = (In == ZERO) ? HUNT0 : HUNT;
      end else begin
        next_state_s = next_state_s;
      end
    end else begin
      next_state_s = state_r;
    end
  end

  // FSM, expected value and registered status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r    <= HUNT;
      exp_r      <= ZERO;
      Locked     <= 1'b0;
      Dir        <= DIR_UP;
      Error      <= 1'b0;
      PeriodTick <= 1'b0;
      PeriodCnt  <= PER_ZERO;
    end else begin
      state_r    <= next_state_s;
      exp_r      <= next_exp_s;
      Locked     <= state_locked(next_state_s);
      Dir        <= state_dir(next_state_s);
      Error      <= mismatch_s;
      PeriodTick <= period_done_s;
      if (period_done_s) PeriodCnt <= PeriodCnt + PER_ONE;
      else               PeriodCnt <= PeriodCnt;
    end
  end

`ifdef BOUNCE_CHK_CAPTURE_EN
  function automatic logic [WIDTH-1:0] wanted_sample(input state_t s, input logic [WIDTH-1:0] e);
    case (s)
      TOP:     wanted_sample = MAX;
      BOT:     wanted_sample = ZERO;
      default: wanted_sample = e;
    endcase
  endfunction

  assign clr_s = ClrCapture;

  // Mismatch capture; a new error overrides a simultaneous clear.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ErrExp <= ZERO;
      ErrGot <= ZERO;
    end else if (mismatch_s) begin
      ErrExp <= wanted_sample(state_r, exp_r);
      ErrGot <= In;
    end else if (ClrCapture) begin
      ErrExp <= ZERO;
      ErrGot <= ZERO;
    end else begin
      ErrExp <= ErrExp;
      ErrGot <= ErrGot;
    end
  end
`else
  assign clr_s = 1'b0;
`endif

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (mismatch_s),
    .clr   (clr_s),
    .q     (ErrCnt)
  );

endmodule

// File: doc/bounce_seq_checker.md
Name: bounce_seq_checker

Overview:
- Receive-side checker for the 4-bit bounce counter stream: 0,1,…,15,15,14,…,0,0,1,…
- Sits on the consumer side of that counter's Out bus.
- Locks onto the sequence, verifies every valid sample against the expected value, flags mismatches, counts errors and completed periods.
- Resynchronises automatically after an error.

Parameters:
- WIDTH, 4: sample width. MAX = 2^WIDTH-1. Period = 2^(WIDTH+1) samples.
- ERR_CNT_W, 8: width of the saturating error counter.
- PER_CNT_W, 8: width of the wrapping period counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- In  in  WIDTH  sample from the bounce counter.
- Valid  in  1  In is sampled only when Valid=1.
- Locked  out  1  1 while tracking a verified sequence.
- Dir  out  1  0 = expecting ascending values (UP/BOT), 1 = expecting descending values (DOWN/TOP).
- Error  out  1  one-cycle pulse on a mismatch while locked.
- PeriodTick  out  1  one-cycle pulse on completion of a full period.
- ErrCnt  out  ERR_CNT_W  saturating mismatch count.
- PeriodCnt  out  PER_CNT_W  wrapping completed-period count.

Behaviour:
- Reset: clock is Clock; reset is Reset, synchronous, active-high.
  - On Reset, state=HUNT, Exp=0, and all outputs are 0.
  - Reset mid-stream takes effect at that edge; the next sample is treated as HUNT.
- Registered outputs: all outputs are registered. A Valid sample at edge N is reflected in the outputs after edge N (one-cycle latency).
- Valid=0: no state, counter or output change, except that Error and PeriodTick return to 0.
- FSM states: HUNT, HUNT0, UP, TOP, DOWN, BOT.
  - HUNT: In==0 → HUNT0; else stay.
  - HUNT0: In==1 → UP, Exp=2, Locked=1; In==0 → stay; else → HUNT.
  - UP: In==Exp.
    - If Exp==MAX → TOP.
    - Else Exp=Exp+1.
  - TOP: In==MAX → DOWN, Exp=MAX-1.
  - DOWN: In==Exp.
    - If Exp==0 → BOT.
    - Else Exp=Exp-1.
  - BOT: In==0 → UP, Exp=1, PeriodTick=1, PeriodCnt+1 (wraps modulo 2^PER_CNT_W).
- Mismatch in UP/TOP/DOWN/BOT:
  - Error=1 for one cycle, ErrCnt+1 (holds at all-ones), Locked=0.
  - Next state is HUNT0 if In==0, else HUNT.
- Mismatches in HUNT/HUNT0 are not errors.
- Boundary cases:
  - A missing endpoint hold (14,15,14) is a mismatch at the second 14.
  - A doubled non-endpoint value is a mismatch.
  - Exp arithmetic is WIDTH bits. No wrap is ever exercised, because the endpoint branches are taken first.

Optional Feature:
- Macro BOUNCE_CHK_CAPTURE_EN.
- Defined:
  - Adds outputs ErrExp[WIDTH] and ErrGot[WIDTH], registered on every Error with the expected and received values; reset to 0.
  - Adds input ClrCapture (1 bit), which zeroes both registers and ErrCnt. An error in the same cycle wins: the new values are captured and ErrCnt becomes 1.
- Undefined: these ports and registers are absent; the rest of the behaviour is identical.

Decomposition:
- Package bounce_chk_pkg:
  - state_t enum {HUNT, HUNT0, UP, TOP, DOWN, BOT}.
  - DIR_UP=1'b0 and DIR_DOWN=1'b1 constants.
- Sub-module sat_counter (parameter W; inputs inc, clr; output q holds at 2^W-1) implements ErrCnt.
- The FSM, Exp register and PeriodCnt stay in the top module.

Test Plan (WIDTH=4):
- Reset, then clean stream 0,0,1..15,15,14..0,0,1:
  - Locked=1 after the edge sampling the first 1.
  - PeriodTick pulses once after the edge sampling the second 0 of the bottom hold, and PeriodCnt=1.
  - Error is never asserted.
- Locked, stream …5,7… (expected 6):
  - Error pulses once, ErrCnt=1, Locked=0.
  - The stream then continues cleanly and Locked returns to 1 after the next 0 followed by 1.
- Top without hold, …14,15,14: Error on the second 14; if the capture macro is enabled, ErrExp=15 and ErrGot=14.
- Random Valid=0 gaps with garbage on In during a clean stream: no Error; PeriodCnt matches the number of completed periods.
- ERR_CNT_W=2, inject 5 mismatches, each followed by a relock: ErrCnt reads 1,2,3,3,3.
- Reset asserted while locked at In=9 in DOWN:
  - After the edge, Locked=0, ErrCnt=0, PeriodCnt=0, Dir=0.
  - The next Valid 0 enters HUNT0.
